mlp_mac_pipe: RTL and testbench

- Parametrised pipelined signed multiply-accumulate engine for the MLP datapath.
- Generalises the fixed 16x28 four-stage DSP multiplier into a configurable design:
  - operand widths and multiply depth are set by parameters;
  - a framed dot-product accumulator delimits each sum;
  - fixed-point round/shift and optional saturation run on the output;
  - valid/ready handshakes run on both sides.
- Sits between the weight/activation fetch stage and the activation-function stage. One dot product goes in as a burst of beats; one neuron pre-activation comes out.

---
 rtl/mlp_mac_pkg.sv | 64 ++++++
 rtl/mlp_mac_mul_pipe.sv | 67 ++++++
 rtl/mlp_mac_pipe.sv | 101 ++++++++++
 tb/tb_mlp_mac_pipe.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_mac_pkg.sv
// Shared types, parameter-legality checks and output-conversion helpers for the
// MLP multiply-accumulate engine.
package mlp_mac_pkg;

    // Wide enough to hold any legal accumulator plus its rounding increment.
    localparam int unsigned CALC_W         = 128;
    localparam int unsigned MIN_MUL_STAGES = 1;
    localparam int unsigned MAX_ACC_W      = CALC_W - 1;

    typedef logic signed [CALC_W-1:0] calc_t;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } beat_sb_t;

    function automatic bit mac_params_ok(
        input int unsigned a_w,
        input int unsigned b_w,
        input int unsigned acc_w,
        input int unsigned out_w,
        input int unsigned frac_shift,
        input int unsigned mul_stages,
        input int unsigned saturate
    );
        return (a_w > 0) && (b_w > 0) && (acc_w >= a_w + b_w) && (acc_w <= MAX_ACC_W) &&
               (out_w > 0) && (out_w < CALC_W) && (frac_shift < acc_w) &&
               (mul_stages >= MIN_MUL_STAGES) && (saturate <= 1);
    endfunction

    // Arithmetic right shift with round-half-toward-+inf.
    function automatic calc_t round_shift(input calc_t v, input int unsigned shift);
        calc_t half;
        if (shift == 0) begin
            return v;
        end
        half = calc_t'(1) <<< (shift - 1);
        return (v + half) >>> shift;
    endfunction

    function automatic calc_t range_max(input int unsigned w);
        return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
    endfunction

    function automatic calc_t range_min(input int unsigned w);
        return -(calc_t'(1) <<< (w - 1));
    endfunction

    function automatic logic out_of_range(input calc_t v, input int unsigned w);
        return (v > range_max(w)) || (v < range_min(w));
    endfunction

    function automatic calc_t sat_clip(input calc_t v, input int unsigned w);
        if (v > range_max(w)) begin
            return range_max(w);
        end
        if (v < range_min(w)) begin
            return range_min(w);
        end
        return v;
    endfunction

endpackage

// File: rtl/mlp_mac_mul_pipe.sv
// MUL_STAGES-deep signed multiplier (input register first) carrying the beat
// sideband alongside the product under one shared advance enable.
module mlp_mac_mul_pipe
    import mlp_mac_pkg::*;
#(
    parameter int unsigned A_W        = 16,
    parameter int unsigned B_W        = 28,
    parameter int unsigned MUL_STAGES = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        adv,
    input  beat_sb_t                    in_sb,
    input  logic signed [A_W-1:0]       a,
    input  logic signed [B_W-1:0]       b,
    output beat_sb_t                    out_sb,
    output logic signed [A_W+B_W-1:0]   p
);

    localparam int unsigned P_W = A_W + B_W;

    beat_sb_t              sb_q [MUL_STAGES];
    logic signed [A_W-1:0] a_q;
    logic signed [B_W-1:0] b_q;

    // Input register and sideband shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(MUL_STAGES); i++) begin
                sb_q[i] <= '0;
            end
            a_q <= '0;
            b_q <= '0;
        end else if (adv) begin
            sb_q[0] <= in_sb;
            for (int i = 1; i < int'(MUL_STAGES); i++) begin
                sb_q[i] <= sb_q[i-1];
            end
            a_q <= a;
            b_q <= b;
        end
    end

    assign out_sb = sb_q[MUL_STAGES-1];

    if (MUL_STAGES == 1) begin : g_comb_mul
        assign p = P_W'(a_q) * P_W'(b_q);
    end else begin : g_reg_mul
        logic signed [P_W-1:0] p_q [MUL_STAGES-1];

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                for (int i = 0; i < int'(MUL_STAGES) - 1; i++) begin
                    p_q[i] <= '0;
                end
            end else if (adv) begin
                p_q[0] <= P_W'(a_q) * P_W'(b_q);
                for (int i = 1; i < int'(MUL_STAGES) - 1; i++) begin
                    p_q[i] <= p_q[i-1];
                end
            end
        end

        assign p = p_q[MUL_STAGES-2];
    end

endmodule

// File: rtl/mlp_mac_pipe.sv
// Pipelined signed MAC: framed dot-product accumulation, round/shift, optional
// saturation and valid/ready handshakes on both sides.
module mlp_mac_pipe
    import mlp_mac_pkg::*;
#(
    parameter int unsigned A_W        = 16,
    parameter int unsigned B_W        = 28,
    parameter int unsigned ACC_W      = 48,
    parameter int unsigned OUT_W      = 32,
    parameter int unsigned FRAC_SHIFT = 12,
    parameter int unsigned MUL_STAGES = 3,
    parameter int unsigned SATURATE   = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ce,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [A_W-1:0]   a,
    input  logic signed [B_W-1:0]   b,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_ovf
);

    localparam int unsigned P_W = A_W + B_W;

    if (!mac_params_ok(A_W, B_W, ACC_W, OUT_W, FRAC_SHIFT, MUL_STAGES, SATURATE)) begin : g_bad_params
        $error("mlp_mac_pipe: illegal parameter combination");
    end

    logic                    stall;
    logic                    adv;
    beat_sb_t                in_sb;
    beat_sb_t                pipe_sb;
    logic signed [P_W-1:0]   pipe_p;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] p_ext;
    logic signed [ACC_W-1:0] sum;
    calc_t                   rnd;
    logic signed [OUT_W-1:0] conv_data;
    logic                    conv_ovf;

    // A held, unconsumed result freezes the whole pipeline.
    assign stall    = out_valid && !out_ready;
    assign adv      = ce && !stall;
    assign in_ready = adv;
    assign in_sb    = '{valid: in_valid, first: in_first, last: in_last};

    mlp_mac_mul_pipe #(
        .A_W        (A_W),
        .B_W        (B_W),
        .MUL_STAGES (MUL_STAGES)
    ) u_mul (
        .clk    (clk),
        .reset  (reset),
        .adv    (adv),
        .in_sb  (in_sb),
        .a      (a),
        .b      (b),
        .out_sb (pipe_sb),
        .p      (pipe_p)
    );

    // Running sum and its converted output form.
    always_comb begin
        p_ext     = ACC_W'(pipe_p);
        sum       = (pipe_sb.first ? '0 : acc_q) + p_ext;
        rnd       = round_shift(calc_t'(sum), FRAC_SHIFT);
        conv_ovf  = out_of_range(rnd, OUT_W);
        conv_data = (SATURATE != 0) ? OUT_W'(sat_clip(rnd, OUT_W)) : OUT_W'(rnd);
    end

    // Accumulator and output register; a result may be replaced on the edge it is consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (ce) begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (adv && pipe_sb.valid) begin
                if (pipe_sb.last) begin
                    acc_q     <= '0;
                    out_valid <= 1'b1;
                    out_data  <= conv_data;
                    out_ovf   <= conv_ovf;
                end else begin
                    acc_q <= sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_mlp_mac_pipe.sv
// Self-checking bench for mlp_mac_pipe: table-driven vectors plus hand-written
// latency, ce, reset and backpressure sequences against a result scoreboard.
module tb_mlp_mac_pipe;

    logic               clk = 1'b0;
    logic               reset;
    logic               ce;
    logic               in_valid;
    logic               in_ready;
    logic               in_ready_t;
    logic signed [15:0] a;
    logic signed [27:0] b;
    logic               in_first;
    logic               in_last;
    logic               out_valid;
    logic               out_valid_t;
    logic               out_ready;
    logic signed [31:0] out_data;
    logic signed [31:0] out_data_t;
    logic               out_ovf;
    logic               out_ovf_t;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rnd_on = 1'b0;

    typedef struct {
        int d;
        bit o;
        int t;
        bit ot;
    } exp_t;

    typedef struct {
        int a;
        int b;
        bit first;
        bit last;
        int exp_d;
        bit exp_o;
    } vec_t;

    exp_t   sbq[$];
    exp_t   mon_e;
    longint macc = 0;
    vec_t   vecs[14];

    mlp_mac_pipe u_dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf)
    );

    mlp_mac_pipe #(.SATURATE(0)) u_trunc (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .in_valid  (in_valid),
        .in_ready  (in_ready_t),
        .a         (a),
        .b         (b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid_t),
        .out_ready (out_ready),
        .out_data  (out_data_t),
        .out_ovf   (out_ovf_t)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference conversion: round half up by 2^12, then clamp or keep low 32 bits.
    task automatic model_result(input longint s, output int d_sat, output bit ovf, output int d_tr);
        longint r;
        r     = (s + 64'sd2048) >>> 12;
        ovf   = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        d_tr  = int'(r);
        d_sat = !ovf ? int'(r) : (r > 0 ? 32'sh7fffffff : 32'sh80000000);
    endtask

    task automatic send_beat(input logic signed [15:0] aa, input logic signed [27:0] bb,
                             input bit f, input bit l, input bit use_exp,
                             input int exp_d, input bit exp_o);
        longint s;
        exp_t   e;
        int     n;
        a        = aa;
        b        = bb;
        in_first = f;
        in_last  = l;
        in_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles, expected 1", n);
                in_valid = 1'b0;
                return;
            end
        end
        @(posedge clk);
        s = (f ? 64'sd0 : macc) + longint'(aa) * longint'(bb);
        s = (s <<< 16) >>> 16;
        if (l) begin
            model_result(s, e.d, e.o, e.t);
            e.ot = e.o;
            if (use_exp) begin
                e.d = exp_d;
                e.o = exp_o;
            end
            sbq.push_back(e);
            macc = 0;
        end else begin
            macc = s;
        end
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", longint'(sbq.size()), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int at_cyc);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        at_cyc = cyc;
    endtask

    // Scoreboard consumer and in_ready rule, sampled mid-cycle.
    always @(negedge clk) begin
        if (!reset) begin
            chk("in_ready", longint'(in_ready), longint'(ce && !(out_valid && !out_ready)));
            chk("in_ready_t", longint'(in_ready_t), longint'(ce && !(out_valid_t && !out_ready)));
            if (ce && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got out_data=%0d, expected no result", out_data);
                end else begin
                    mon_e = sbq.pop_front();
                    chk("out_data", longint'(out_data), longint'(mon_e.d));
                    chk("out_ovf", longint'(out_ovf), longint'(mon_e.o));
                    chk("trunc_valid", longint'(out_valid_t), 1);
                    chk("trunc_data", longint'(out_data_t), longint'(mon_e.t));
                    chk("trunc_ovf", longint'(out_ovf_t), longint'(mon_e.ot));
                end
            end
        end
    end

    // Random downstream backpressure during the soak phase.
    always begin
        @(posedge clk);
        #1;
        if (rnd_on) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1, d_base, d_ce;

        vecs[0]  = '{4096, 8192, 1, 1, 8192, 0};
        vecs[1]  = '{4096, 100, 1, 0, 0, 0};
        vecs[2]  = '{8192, -50, 0, 0, 0, 0};
        vecs[3]  = '{-4096, 25, 0, 1, -25, 0};
        vecs[4]  = '{1, 2048, 1, 1, 1, 0};
        vecs[5]  = '{1, 2047, 1, 1, 0, 0};
        vecs[6]  = '{1, -2048, 1, 1, 0, 0};
        vecs[7]  = '{1, -2049, 1, 1, -1, 0};
        vecs[8]  = '{32767, 134217727, 1, 0, 0, 0};
        vecs[9]  = '{32767, 134217727, 0, 0, 0, 0};
        vecs[10] = '{32767, 134217727, 0, 1, 2147483647, 1};
        vecs[11] = '{4096, 4096, 0, 1, 4096, 0};
        vecs[12] = '{4096, 4096, 1, 0, 0, 0};
        vecs[13] = '{4096, 8192, 1, 1, 8192, 0};

        reset     = 1'b1;
        ce        = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        #1;
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_out_data", longint'(out_data), 0);
        chk("reset_out_ovf", longint'(out_ovf), 0);
        chk("reset_in_ready", longint'(in_ready), 1);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        // Single-beat latency.
        send_beat(16'sd4096, 28'sd8192, 1'b1, 1'b1, 1'b1, 8192, 1'b0);
        c0 = cyc;
        wait_out(c1);
        chk("single_latency", longint'(c1 - c0), 3);
        drain();

        // Table vectors.
        for (int i = 0; i < 14; i++) begin
            send_beat(16'(vecs[i].a), 28'(vecs[i].b), vecs[i].first, vecs[i].last,
                      1'b1, vecs[i].exp_d, vecs[i].exp_o);
        end
        drain();

        // Three-beat burst, uninterrupted then with ce low for 3 cycles.
        send_beat(16'sd4096, 28'sd100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        c0 = cyc;
        send_beat(16'sd8192, -28'sd50, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send_beat(-16'sd4096, 28'sd25, 1'b0, 1'b1, 1'b1, -25, 1'b0);
        wait_out(c1);
        d_base = c1 - c0;
        chk("burst_latency", longint'(d_base), 5);
        drain();

        send_beat(16'sd4096, 28'sd100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        c0 = cyc;
        ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        ce = 1'b1;
        send_beat(16'sd8192, -28'sd50, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        send_beat(-16'sd4096, 28'sd25, 1'b0, 1'b1, 1'b1, -25, 1'b0);
        wait_out(c1);
        d_ce = c1 - c0;
        chk("ce_delay", longint'(d_ce - d_base), 3);
        drain();

        // Reset mid-burst, then a burst that would expose any residue.
        send_beat(16'sd4096, 28'sd100, 1'b1, 1'b0, 1'b0, 0, 1'b0);
        send_beat(16'sd4096, 28'sd100, 1'b0, 1'b0, 1'b0, 0, 1'b0);
        reset = 1'b1;
        macc  = 0;
        sbq.delete();
        #1;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_out_data", longint'(out_data), 0);
        chk("midrst_out_ovf", longint'(out_ovf), 0);
        chk("midrst_trunc_data", longint'(out_data_t), 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        send_beat(16'sd4096, 28'sd4096, 1'b0, 1'b1, 1'b1, 4096, 1'b0);
        drain();

        // Backpressure: six back-to-back results, out_ready low for 5 cycles.
        out_ready = 1'b0;
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    send_beat(16'(4096 * (k + 1)), 28'sd4096, 1'b1, 1'b1, 1'b0, 0, 1'b0);
                end
            end
            begin
                int n;
                n = 0;
                while (!out_valid && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                @(negedge clk);
                chk("bp_stalled_in_ready", longint'(in_ready), 0);
                chk("bp_stalled_valid", longint'(out_valid), 1);
                repeat (4) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Random soak with random downstream backpressure.
        rnd_on = 1'b1;
        for (int n = 0; n < 15; n++) begin
            int len;
            len = int'($urandom_range(1, 4));
            for (int j = 0; j < len; j++) begin
                int ra, rb;
                ra = int'($urandom_range(0, 600)) - 300;
                rb = int'($urandom_range(0, 20000)) - 10000;
                send_beat(16'(ra), 28'(rb), j == 0, j == len - 1, 1'b0, 0, 1'b0);
            end
        end
        @(negedge clk);
        rnd_on    = 1'b0;
        out_ready = 1'b1;
        drain();

        chk("final_queue_empty", longint'(sbq.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
